// File: rtl/aes_inv_round_lin.sv
// rtl/aes_inv_round_lin.sv - AES inverse round linear layer: AddRoundKey, InvMixColumns, InvShiftRows
// Optional macro AES_INV_BLKCNT_EN adds the blk_cnt output-transfer counter.
module aes_inv_round_lin #(
  parameter int PIPE_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] round_key,
  input  logic         in_skip_mix,
  input  logic         in_skip_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
`ifdef AES_INV_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers composed from xtime chains: x2, x4, x8 and XORs.
  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Column c occupies bytes 4c..4c+3, row r of column c sits at bits [127-32c-8r -: 8].
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      r[119-32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      r[111-32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      r[103-32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end
    return r;
  endfunction

  // Row r rotates right by r: out[r][c] takes in[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  logic [127:0] ark;
  logic [127:0] mixed;

  // Key addition followed by the optional column mix, shared by both pipeline shapes.
  always_comb begin
    ark   = in_block ^ round_key;
    mixed = in_skip_mix ? ark : inv_mix_columns(ark);
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      logic         v1;
      logic [127:0] d1;
      logic         rdy1;

      assign rdy1      = !v1 || out_ready;
      assign in_ready  = rdy1;
      assign out_valid = v1;
      assign out_block = d1;

      // Single stage: all three operations land in one register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1 <= 1'b0;
          d1 <= '0;
        end else if (rdy1) begin
          v1 <= in_valid;
          if (in_valid) begin
            d1 <= in_skip_shift ? mixed : inv_shift_rows(mixed);
          end
        end
      end
    end else if (PIPE_STAGES == 2) begin : g_two
      logic         v1, v2;
      logic         s1;
      logic [127:0] d1, d2;
      logic         rdy1, rdy2;

      assign rdy2      = !v2 || out_ready;
      assign rdy1      = !v1 || rdy2;
      assign in_ready  = rdy1;
      assign out_valid = v2;
      assign out_block = d2;

      // Stage 1: key addition and column mix; the shift-skip flag rides along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1 <= 1'b0;
          d1 <= '0;
          s1 <= 1'b0;
        end else if (rdy1) begin
          v1 <= in_valid;
          if (in_valid) begin
            d1 <= mixed;
            s1 <= in_skip_shift;
          end
        end
      end

      // Stage 2: row rotation using the flag captured with this block.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else if (rdy2) begin
          v2 <= v1;
          if (v1) begin
            d2 <= s1 ? d1 : inv_shift_rows(d1);
          end
        end
      end
    end else begin : g_bad
      $error("aes_inv_round_lin: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

`ifdef AES_INV_BLKCNT_EN
  // Count completed output transfers, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_inv_round_lin.sv
// tb/tb_aes_inv_round_lin.sv - self-checking bench for aes_inv_round_lin
module tb_aes_inv_round_lin;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic [127:0] round_key = '0;
  logic         in_skip_mix = 1'b0;
  logic         in_skip_shift = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
`ifdef AES_INV_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  aes_inv_round_lin #(.PIPE_STAGES(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_block(in_block),
    .round_key(round_key),
    .in_skip_mix(in_skip_mix),
    .in_skip_shift(in_skip_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block)
`ifdef AES_INV_BLKCNT_EN
    ,
    .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Reference: state as a 4x4 matrix, circulant inverse-mix matrix, row rotation.
  function automatic logic [127:0] model(input logic [127:0] blk, input logic [127:0] key,
                                         input logic smix, input logic sshift);
    logic [7:0]   st[4][4];
    logic [7:0]   t[4][4];
    logic [7:0]   coef[4];
    logic [7:0]   acc;
    logic [127:0] x, r;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    x = blk ^ key;
    for (int k = 0; k < 16; k++) st[k%4][k/4] = x[127-8*k -: 8];
    if (!smix) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-rw+4)%4], st[j][c]);
          t[rw][c] = acc;
        end
      st = t;
    end
    if (!sshift) begin
      for (int rw = 0; rw < 4; rw++)
        for (int c = 0; c < 4; c++) t[rw][c] = st[rw][(c-rw+4)%4];
      st = t;
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = st[k%4][k/4];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Observes the handshake just before the next edge, then advances one cycle.
  task automatic tick(output logic acc, output logic oxf, output logic [127:0] ob);
    #1;
    acc = in_valid && in_ready;
    oxf = out_valid && out_ready;
    ob  = out_block;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_q.delete();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_block !== 128'h0) begin errors++; $display("FAIL reset_out_block got=%h exp=0", out_block); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    logic [127:0] vb[4], vk[4], ve[4];
    logic         vm[4], vs[4];
    logic         acc, oxf;
    logic [127:0] ob;
    int           lat;
    exp_q.delete();
    vb[0] = 128'h000102030405060708090a0b0c0d0e0f; vk[0] = '0; vm[0] = 1'b1; vs[0] = 1'b0;
    ve[0] = 128'h000d0a0704010e0b0805020f0c090603;
    vb[1] = 128'h8e4da1bc9fdc589d01010101c6c6c6c6; vk[1] = '0; vm[1] = 1'b0; vs[1] = 1'b1;
    ve[1] = 128'hdb135345f20a225c01010101c6c6c6c6;
    vb[2] = {128{1'b1}}; vk[2] = 128'h71b25e436023a762fefefefe39393939; vm[2] = 1'b0; vs[2] = 1'b1;
    ve[2] = 128'hdb135345f20a225c01010101c6c6c6c6;
    vb[3] = '0; vk[3] = rnd128(); vm[3] = 1'b1; vs[3] = 1'b1;
    ve[3] = vk[3];
    for (int v = 0; v < 4; v++) begin
      in_block = vb[v]; round_key = vk[v]; in_skip_mix = vm[v]; in_skip_shift = vs[v];
      in_valid = 1'b1; out_ready = 1'b1;
      tick(acc, oxf, ob);
      in_valid = 1'b0;
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL vec%0d_accept got=%b exp=1", v, acc); end
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != P) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", v, lat, P); end
      checks++;
      if (out_block !== ve[v]) begin errors++; $display("FAIL vec%0d_data got=%h exp=%h", v, out_block, ve[v]); end
      tick(acc, oxf, ob);
    end
  endtask

  task automatic test_back_to_back();
    logic         acc, oxf;
    logic [127:0] ob, e;
    int sent, nout, first, last, stall;
    exp_q.delete();
    sent = 0; nout = 0; first = -1; last = -1; stall = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_block = rnd128(); round_key = rnd128();
        in_skip_mix = $urandom_range(0, 1); in_skip_shift = $urandom_range(0, 1);
      end
      tick(acc, oxf, ob);
      if (in_valid && !acc) stall++;
      if (acc) begin
        exp_q.push_back(model(in_block, round_key, in_skip_mix, in_skip_shift));
        sent++;
      end
      if (oxf) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (ob !== e) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", nout, ob, e); end
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (stall != 0) begin errors++; $display("FAIL b2b_in_stall got=%0d exp=0", stall); end
    checks++;
    if (nout != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", nout); end
    checks++;
    if (last - first != 7) begin errors++; $display("FAIL b2b_gapless got=%0d exp=7", last - first); end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk[4], key[4];
    logic         sm[4], ss[4];
    logic         acc, oxf, have_prev;
    logic [127:0] ob, prev, e;
    int idx, got, extra, stable_bad;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      blk[i] = rnd128(); key[i] = rnd128();
      sm[i] = $urandom_range(0, 1); ss[i] = $urandom_range(0, 1);
    end
    idx = 0; stable_bad = 0; have_prev = 1'b0; prev = '0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_block = blk[idx]; round_key = key[idx]; in_skip_mix = sm[idx]; in_skip_shift = ss[idx];
      end
      tick(acc, oxf, ob);
      if (acc) begin
        exp_q.push_back(model(in_block, round_key, in_skip_mix, in_skip_shift));
        idx++;
      end
      if (out_valid) begin
        if (have_prev && out_block !== prev) stable_bad++;
        prev = out_block;
        have_prev = 1'b1;
      end
    end
    #1;
    checks++;
    if (idx != P) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", idx, P); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (!have_prev || stable_bad != 0) begin
      errors++; $display("FAIL bp_stable got=%0d changes (seen=%b) exp=0", stable_bad, have_prev);
    end
    checks++;
    if (exp_q.size() == 0 || out_block !== exp_q[0]) begin
      errors++; $display("FAIL bp_head got=%h exp=%h", out_block, (exp_q.size() > 0) ? exp_q[0] : 'x);
    end
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_block = blk[idx]; round_key = key[idx]; in_skip_mix = sm[idx]; in_skip_shift = ss[idx];
      end
      tick(acc, oxf, ob);
      if (acc) begin
        exp_q.push_back(model(in_block, round_key, in_skip_mix, in_skip_shift));
        idx++;
      end
      if (oxf) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (ob !== e) begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", got, ob, e); end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got); end
    extra = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick(acc, oxf, ob);
      if (oxf) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL bp_no_dup got=%0d exp=0", extra); end
  endtask

  task automatic test_random();
    logic         acc, oxf;
    logic [127:0] ob, e;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_block = rnd128(); round_key = rnd128();
      in_skip_mix = $urandom_range(0, 1); in_skip_shift = $urandom_range(0, 1);
      tick(acc, oxf, ob);
      if (acc) exp_q.push_back(model(in_block, round_key, in_skip_mix, in_skip_shift));
      if (oxf) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious got=%h exp=none", ob);
        end else begin
          e = exp_q.pop_front();
          if (ob !== e) begin errors++; $display("FAIL rand_data got=%h exp=%h", ob, e); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick(acc, oxf, ob);
      if (oxf) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious got=%h exp=none", ob);
        end else begin
          e = exp_q.pop_front();
          if (ob !== e) begin errors++; $display("FAIL rand_drain got=%h exp=%h", ob, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic         acc, oxf;
    logic [127:0] ob, e;
    int got;
    exp_q.delete();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      in_valid = 1'b1;
      in_block = rnd128(); round_key = rnd128();
      in_skip_mix = $urandom_range(0, 1); in_skip_shift = $urandom_range(0, 1);
      tick(acc, oxf, ob);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_preload got=%b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_block !== 128'h0) begin errors++; $display("FAIL rm_out_block got=%h exp=0", out_block); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_block = rnd128(); round_key = rnd128();
    in_skip_mix = 1'b0; in_skip_shift = 1'b0;
    tick(acc, oxf, ob);
    if (acc) exp_q.push_back(model(in_block, round_key, in_skip_mix, in_skip_shift));
    in_valid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick(acc, oxf, ob);
      if (oxf) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rm_stale got=%h exp=none", ob);
        end else begin
          e = exp_q.pop_front();
          if (ob !== e) begin errors++; $display("FAIL rm_first got=%h exp=%h", ob, e); end
        end
        got++;
      end
    end
    checks++;
    if (got != 1) begin errors++; $display("FAIL rm_count got=%0d exp=1", got); end
  endtask

`ifdef AES_INV_BLKCNT_EN
  task automatic test_blkcnt();
    logic         acc, oxf;
    logic [127:0] ob;
    logic [15:0]  held;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (blk_cnt !== 16'h0) begin errors++; $display("FAIL cnt_reset got=%h exp=0", blk_cnt); end
    out_ready = 1'b1; in_valid = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 70000 && n < 65537; cyc++) begin
      tick(acc, oxf, ob);
      if (oxf) n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (blk_cnt !== 16'h0001) begin errors++; $display("FAIL cnt_wrap got=%h exp=0001 (transfers=%0d)", blk_cnt, n); end
    held = 16'h0001;
    repeat (5) tick(acc, oxf, ob);
    checks++;
    if (blk_cnt !== held) begin errors++; $display("FAIL cnt_hold got=%h exp=%h", blk_cnt, held); end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef AES_INV_BLKCNT_EN
    test_blkcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_lin.md
Name: aes_inv_round_lin

Overview:
- Linear layer of one AES inverse-cipher (decryption) round: AddRoundKey, then InvMixColumns, then InvShiftRows.
- It is the decrypt-side counterpart of the encrypt ShiftRows datapath.
- InvSubBytes is done upstream; InvSubBytes commutes with InvShiftRows, so the result feeds the next round's S-box stage directly.
- Pipelined, one block per cycle sustained, valid/ready handshake on both sides.

Parameters:
PIPE_STAGES, 2, register stages: 1 = all three ops in one stage; 2 = AddRoundKey+InvMixColumns in stage 1, InvShiftRows in stage 2. Any other value is a elaboration error.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  input block valid
in_ready  output  1  block accepts input this cycle
in_block  input  128  state; AES byte k (k=0..15, column-major, row=k%4, col=k/4) at bits [127-8k -: 8]
round_key  input  128  round key, same byte order, sampled with in_block
in_skip_mix  input  1  bypass InvMixColumns for this block (first/last round)
in_skip_shift  input  1  bypass InvShiftRows for this block (final round)
out_valid  output  1  output block valid
out_ready  input  1  downstream accepts output
out_block  output  128  result, same byte order

Behaviour:
- Interface: one clock (clk); reset asynchronous, active low (rst_n).
- Transfer occurs on a clk edge with valid && ready, on both ports.
- Reset: out_valid=0, out_block=0, all stage valids 0, stored skip flags 0. in_ready is 1 combinationally once rst_n=1.
- Reset asserted mid-operation drops every in-flight block; no partial output.
- Stage k holds valid_k, data and skip flags. ready_k = !valid_k || ready_(k+1); ready after the last stage = out_ready. in_ready = ready_1.
- Stage loads when ready_k. On load, valid_k takes the upstream valid; data is held while not ready.
- Latency: PIPE_STAGES cycles from input transfer to out_valid. Full throughput while out_ready=1; no bubbles inserted.
- Backpressure: with out_ready=0 the pipe fills, then in_ready=0. out_block and out_valid are stable while out_valid && !out_ready.
- Skip flags travel with their block. Flags change per transfer with no penalty.
- AddRoundKey: x = in_block ^ round_key.
- InvMixColumns (unless skip_mix), per column a0..a3 (a0 = row 0):
  - b0=0e*a0^0b*a1^0d*a2^09*a3
  - b1=09*a0^0e*a1^0b*a2^0d*a3
  - b2=0d*a0^09*a1^0e*a2^0b*a3
  - b3=0b*a0^0d*a1^09*a2^0e*a3
  - GF(2^8) multiply, poly 0x11B, built from xtime chains (no multipliers).
- InvShiftRows (unless skip_shift): out[r][c] = in[r][(c-r) mod 4]. Row 0 is unchanged; rows 1/2/3 rotate right by 1/2/3.
- Stored skip flags are observable only through the data result.

Optional Feature:
AES_INV_BLKCNT_EN defined:
- Adds output blk_cnt[15:0], reset 0.
- Increments on each output transfer; wraps 0xFFFF->0x0000.
- Pure side-band; does not affect data or handshake timing.

Not defined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- InvShiftRows only: in_block=000102030405060708090a0b0c0d0e0f, key=0, skip_mix=1, skip_shift=0 -> out_block=000d0a0704010e0b0805020f0c090603, PIPE_STAGES cycles after transfer.
- InvMixColumns only: in_block=8e4da1bc9fdc589d01010101c6c6c6c6, key=0, skip_mix=0, skip_shift=1 -> out_block=db135345f20a225c01010101c6c6c6c6.
- Key plus mix: in_block=all ones, round_key=71b25e436023a762fefefefe39393939, skip_shift=1 -> out_block=db135345f20a225c01010101c6c6c6c6. Both skips with in_block=0 -> out_block=round_key.
- Backpressure: stream 4 distinct blocks, out_ready=0 for 5 cycles:
  - in_ready falls after PIPE_STAGES accepts; out_block is stable.
  - On release, all 4 blocks emerge in order with no loss or duplicate.
  - With out_ready=1, back-to-back inputs give out_valid=1 every cycle.
- Reset mid-stream: assert rst_n=0 with 2 blocks in flight -> out_valid=0 and out_block=0 immediately. After release, the first new block's output is correct and nothing stale appears.
- AES_INV_BLKCNT_EN: 65537 output transfers -> blk_cnt=1. blk_cnt is unchanged while out_ready=0.
